// File: rtl/mul52_round_sat_pkg.sv
// -----------------------------------------------------------------------------
// mul52_round_sat_pkg
// Widths, output limits and the saturation helper shared by the 52x52
// multiplier post-processing stage. The multiplier and this block both
// import these definitions so their product and output widths cannot drift
// apart.
// -----------------------------------------------------------------------------
package mul52_round_sat_pkg;

   localparam int W_PROD = 103;           // signed product from the multiplier
   localparam int W_OUT  = 52;            // signed rounded/saturated result
   localparam int W_EXT  = W_PROD + 1;    // product plus one guard bit for the bias add

   localparam logic [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};  //  2^51 - 1
   localparam logic [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};  // -2^51

   // One FIFO word: saturation flag above the result.
   typedef struct packed {
      logic             sat;
      logic [W_OUT-1:0] d;
   } result_t;

   // Rounding bias for half-toward-+inf before an arithmetic right shift.
   function automatic logic signed [W_EXT-1:0] round_bias(input int shift);
      logic signed [W_EXT-1:0] one;
      one = W_EXT'(1);
      if (shift > 0) return one <<< (shift - 1);
      return '0;
   endfunction

   // Clamp a shifted value to W_OUT signed bits.
   function automatic result_t saturate(input logic signed [W_EXT-1:0] r);
      result_t res;
      // The value fits only if every bit from the output sign bit upward is
      // a copy of the extended sign.
      if (r[W_EXT-1:W_OUT-1] == '0 || r[W_EXT-1:W_OUT-1] == '1) begin
         res.sat = 1'b0;
         res.d   = r[W_OUT-1:0];
      end else if (r[W_EXT-1]) begin
         res.sat = 1'b1;
         res.d   = OUT_MIN;
      end else begin
         res.sat = 1'b1;
         res.d   = OUT_MAX;
      end
      return res;
   endfunction

endpackage

// File: rtl/mul52_round_sat_if.sv
// -----------------------------------------------------------------------------
// mul52_round_sat_if
// Product input strobe and FWFT result stream of mul52_round_sat.
//   i_c_en / i_c          : product strobe and 103-bit signed product
//   o_d / o_d_sat / o_d_vld : FIFO head word, its saturation flag, non-empty
//   i_d_rdy               : consumer ready (pops the head when o_d_vld)
// master = the surrounding logic (multiplier + consumer), slave = the block.
// -----------------------------------------------------------------------------
interface mul52_round_sat_if;
   import mul52_round_sat_pkg::*;

   logic              i_c_en;
   logic [W_PROD-1:0] i_c;
   logic [W_OUT-1:0]  o_d;
   logic              o_d_sat;
   logic              o_d_vld;
   logic              i_d_rdy;

   modport master (
      output i_c_en, i_c, i_d_rdy,
      input  o_d, o_d_sat, o_d_vld
   );

   modport slave (
      input  i_c_en, i_c, i_d_rdy,
      output o_d, o_d_sat, o_d_vld
   );

endinterface

// File: rtl/mul52_round_sat_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// First-word-fall-through synchronous FIFO. rd_data shows the head entry
// whenever the FIFO is non-empty and reads as zero when empty.
//   i_clk, i_rst : clock, synchronous active-high reset
//   wr_en/wr_data: write; accepted when not full, or when full with a
//                  same-cycle read
//   rd_en/rd_data: pop the head; ignored while empty
//   empty, full, count : occupancy
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH = 53,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_rd;
   logic             do_wr;

   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign count = cnt;

   // A write into a full FIFO is accepted only when the head leaves in the
   // same cycle; the freed slot is the one being written.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage has no reset; pointers and count define validity, and the
   // empty mask below keeps stale contents off the output.
   always_ff @(posedge i_clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mul52_round_sat.sv
// -----------------------------------------------------------------------------
// mul52_round_sat
// Rounds each 103-bit signed product to nearest (half toward +inf) at a fixed
// binary point, saturates to 52-bit signed and queues it in an FWFT FIFO.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : product strobe/data in, result stream out
//   o_afull      : upstream must stop issuing multiplies (level)
//   o_drop       : sticky, a result was lost to a full FIFO
//   o_sat_cnt    : saturated-result count, holds at 16'hFFFF
// Latency: product sampled at E0, written to the FIFO at E1.
// -----------------------------------------------------------------------------
module mul52_round_sat
   import mul52_round_sat_pkg::*;
#(
   parameter int SHIFT        = 50,
   parameter int FIFO_DEPTH   = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   mul52_round_sat_if.slave       bus,
   output logic                   o_afull,
   output logic                   o_drop,
   output logic [15:0]            o_sat_cnt
);

   localparam logic signed [W_EXT-1:0] BIAS = round_bias(SHIFT);
   localparam int                      CW   = $clog2(FIFO_DEPTH) + 1;

   logic signed [W_EXT-1:0] s1_r;
   logic                    s1_vld;
   result_t                 s2;
   result_t                 head;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [CW-1:0]           fifo_count;
   logic                    pop;

   // Stage S1: sign-extend one bit so the bias add cannot overflow, then
   // shift arithmetically; floor(x + 0.5) is round-half-toward-+inf.
   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_vld <= 1'b0;
         s1_r   <= '0;
      end else begin
         s1_vld <= bus.i_c_en;
         if (bus.i_c_en)
            s1_r <= ($signed({bus.i_c[W_PROD-1], bus.i_c}) + BIAS) >>> SHIFT;
      end
   end

   // Stage S2: saturation, written into the FIFO on the next edge.
   assign s2  = saturate(s1_r);
   assign pop = ~fifo_empty & bus.i_d_rdy;

   sync_fifo_fwft #(
      .WIDTH (W_OUT + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (s1_vld),
      .wr_data (s2),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign bus.o_d     = head.d;
   assign bus.o_d_sat = head.sat;
   assign bus.o_d_vld = ~fifo_empty;

   // Drop flag and saturation counter; a dropped word still counts as
   // saturated if it was.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_drop    <= 1'b0;
         o_sat_cnt <= '0;
      end else begin
         if (s1_vld && fifo_full && !pop) o_drop <= 1'b1;
         if (s1_vld && s2.sat && o_sat_cnt != 16'hFFFF)
            o_sat_cnt <= o_sat_cnt + 16'd1;
      end
   end

   // The in-flight S1 word counts as occupied so the stop reaches upstream
   // before that word lands.
   // NOTE: default assignment first so no path leaves o_afull unassigned,
   // which would infer a latch.
   always_comb begin
      o_afull = 1'b0;
      if ((int'(fifo_count) + int'(s1_vld)) >= (FIFO_DEPTH - AFULL_MARGIN))
         o_afull = 1'b1;
   end

endmodule
